muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit implementing all eight RV32M/RV64M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for an XLEN-bit datapath.
- Successor to the single-cycle `alu`: it sits beside the ALU in the execute stage and takes operands from the register file.
- It uses a valid/ready handshake on both sides, so the core stalls while an operation is in flight.
- Multi-cycle shift-add / restoring-division datapath, with a fast-path for divide special cases.

---
 rtl/muldiv_unit.sv | 172 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit with valid/ready handshake on both sides.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiplier for MUL/MULH/MULHSU/MULHU.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            kill_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);
  // state | meaning
  // IDLE  | waiting for a request, result held at zero
  // CALC  | one multiplier/quotient bit per cycle
  // DONE  | result valid, waiting for out_ready
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   dsr_q, dsr_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic            sign_a, sign_b, div_by_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    sign_a = a_i[XLEN-1] && (op_i == OP_MULH || op_i == OP_MULHSU ||
                             op_i == OP_DIV  || op_i == OP_REM);
    sign_b = b_i[XLEN-1] && (op_i == OP_MULH || op_i == OP_DIV || op_i == OP_REM);
    mag_a  = sign_a ? -a_i : a_i;
    mag_b  = sign_b ? -b_i : b_i;
    div_by_zero = op_i[2] && (b_i == '0);
    div_ovf     = (op_i == OP_DIV || op_i == OP_REM) && (a_i == MOST_NEG) && (b_i == '1);
  end

  // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}
  logic [XLEN:0]     mul_sum, div_shift;
  logic              div_ge;
  logic [2*XLEN-1:0] step;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dsr_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, dsr_q};
    if (op_q[2])
      step = {(div_ge ? div_shift[XLEN-1:0] - dsr_q : div_shift[XLEN-1:0]),
              acc_q[XLEN-2:0], div_ge};
    else
      step = {mul_sum, acc_q[XLEN-1:1]};
  end

  function automatic logic [XLEN-1:0] finish_op(input logic [2:0] op, input logic neg,
                                                input logic [2*XLEN-1:0] acc);
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   v;
    logic [XLEN-1:0]   r;
    p = neg ? -acc : acc;
    v = op[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    if (!op[2])
      r = (op == OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    else
      r = neg ? -v : v;
    return r;
  endfunction

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_p;
  always_comb begin
    fast_a = {{XLEN{sign_a}}, a_i};
    fast_b = {{XLEN{sign_b}}, b_i};
    fast_p = fast_a * fast_b;
  end
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    dsr_d    = dsr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i && !kill_i) begin
          op_d  = op_i;
          neg_d = (op_i[2] && op_i[1]) ? sign_a : (sign_a ^ sign_b);
          dsr_d = mag_b;
          acc_d = {{XLEN{1'b0}}, mag_a};
          cnt_d = CW'(XLEN);
          if (div_by_zero) begin
            result_d = op_i[1] ? a_i : '1;
            state_d  = S_DONE;
          end else if (div_ovf) begin
            result_d = op_i[1] ? '0 : a_i;
            state_d  = S_DONE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!op_i[2]) begin
            result_d = (op_i == OP_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
            state_d  = S_DONE;
`endif
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (kill_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_d = finish_op(op_q, neg_q, step);
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (kill_i || out_ready_i) begin
          result_d = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      dsr_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      dsr_q    <= dsr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);
  assign result_o    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed table, random ops vs. arithmetic model,
// and hand-written backpressure / kill / reset sequences.
module tb_muldiv_unit;
  localparam int XLEN = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = XLEN;
`endif

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        in_valid, in_ready, kill, out_valid, out_ready, busy;
  logic [2:0]  op;
  logic [31:0] a, b, result;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .a_i(a), .b_i(b), .kill_i(kill), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .result_o(result), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on sign-extended operands, RISC-V rules for divide corners.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [65:0] xa, yb, p;
    logic [31:0] r;
    xa = (o == 3'd1 || o == 3'd2) ? {{34{x[31]}}, x} : {34'b0, x};
    yb = (o == 3'd1) ? {{34{y[31]}}, y} : {34'b0, y};
    p  = xa * yb;
    case (o)
      3'd0: r = p[31:0];
      3'd1, 3'd2, 3'd3: r = p[63:32];
      3'd4: if (y == 0) r = '1; else if (x == MIN && y == '1) r = x; else r = $signed(x) / $signed(y);
      3'd5: if (y == 0) r = '1; else r = x / y;
      3'd6: if (y == 0) r = x; else if (x == MIN && y == '1) r = '0; else r = $signed(x) % $signed(y);
      default: if (y == 0) r = x; else r = x % y;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && y == 0) return 0;
    if ((o == 3'd4 || o == 3'd6) && x == MIN && y == '1) return 0;
    if (!o[2]) return MUL_LAT;
    return XLEN;
  endfunction

  // lat = clock edges after the accept edge until out_valid is seen
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output int lat);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    if (out_valid && out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  initial begin
    logic [31:0] res;
    int lat;
    logic seen;

    vecs[0]  = '{3'd0, 32'd3006,      32'd3005,      32'd9033030,   MUL_LAT};
    vecs[1]  = '{3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  MUL_LAT};
    vecs[2]  = '{3'd1, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000,  MUL_LAT};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF,  32'd2,         32'hFFFFFFFF,  MUL_LAT};
    vecs[4]  = '{3'd4, -32'sd7,       32'd2,         32'hFFFFFFFD,  XLEN};
    vecs[5]  = '{3'd6, -32'sd7,       32'd2,         32'hFFFFFFFF,  XLEN};
    vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        XLEN};
    vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         XLEN};
    vecs[8]  = '{3'd5, 32'd100,       32'd0,         32'hFFFFFFFF,  0};
    vecs[9]  = '{3'd7, 32'd100,       32'd0,         32'd100,       0};
    vecs[10] = '{3'd4, MIN,           32'hFFFFFFFF,  MIN,           0};
    vecs[11] = '{3'd6, MIN,           32'hFFFFFFFF,  32'd0,         0};
    vecs[12] = '{3'd0, -32'sd5,       32'd7,         32'hFFFFFFDD,  MUL_LAT};
    vecs[13] = '{3'd4, 32'd7,         -32'sd2,       32'hFFFFFFFD,  XLEN};
    vecs[14] = '{3'd6, 32'd7,         -32'sd2,       32'd1,         XLEN};
    vecs[15] = '{3'd4, -32'sd7,       32'd0,         32'hFFFFFFFF,  0};
    vecs[16] = '{3'd6, -32'sd7,       32'd0,         32'hFFFFFFF9,  0};
    vecs[17] = '{3'd4, MIN,           32'd1,         MIN,           XLEN};

    reset_ni = 1'b0; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b1;
    op = '0; a = '0; b = '0;
    #1;
    check("reset_in_ready",  32'(in_ready),  32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy",      32'(busy),      32'd0);
    check("reset_result",    result,         32'd0);
    repeat (3) @(posedge clk);
    #1 reset_ni = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].res);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_idle_after", i), 32'(in_ready), 32'd1);
    end

    for (int n = 0; n < 300; n++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = MIN; rb = '1; end
        2: begin ra = 32'($urandom_range(0, 300)) - 32'd150; rb = 32'($urandom_range(0, 20)) - 32'd10; end
        default: ;
      endcase
      do_op(ro, ra, rb, res, lat);
      check($sformatf("rand%0d_op%0d_result", n, ro), res, model(ro, ra, rb));
      check($sformatf("rand%0d_op%0d_latency", n, ro), 32'(lat), 32'(exp_lat(ro, ra, rb)));
    end

    // backpressure in DONE, then handshake and an immediate new request
    out_ready = 1'b0;
    do_op(3'd5, 32'd100, 32'd7, res, lat);
    check("bp_first_result", res, 32'd14);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_result", c), result, 32'd14);
      check($sformatf("bp_hold%0d_in_ready", c), 32'(in_ready), 32'd0);
      check($sformatf("bp_hold%0d_out_valid", c), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    op = 3'd3; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_result", result, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_accepted", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_next_result", result, 32'hFFFFFFFE);
    check("bp_next_latency", 32'(lat), 32'(MUL_LAT));
    @(posedge clk); #1;

    // kill during the 10th CALC cycle of a DIV
    op = 3'd4; a = -32'sd7; b = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_calc_in_ready", 32'(in_ready), 32'd1);
    check("kill_calc_out_valid", 32'(out_valid), 32'd0);
    check("kill_calc_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    repeat (XLEN + 5) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    check("kill_calc_no_out_valid", 32'(seen), 32'd0);

    // kill in DONE
    out_ready = 1'b0;
    do_op(3'd5, 32'd9, 32'd0, res, lat);
    check("kill_done_pre_valid", 32'(out_valid), 32'd1);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_done_out_valid", 32'(out_valid), 32'd0);
    check("kill_done_in_ready", 32'(in_ready), 32'd1);
    check("kill_done_result", result, 32'd0);

    // kill in IDLE beats a simultaneous request
    out_ready = 1'b1;
    op = 3'd5; a = 32'd9; b = 32'd0; in_valid = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    check("kill_idle_not_taken_ready", 32'(in_ready), 32'd1);
    check("kill_idle_not_taken_valid", 32'(out_valid), 32'd0);

    // asynchronous reset in DONE (nonzero result) and mid-CALC
    out_ready = 1'b0;
    do_op(3'd5, 32'd100, 32'd0, res, lat);
    check("rst_done_pre_result", result, 32'hFFFFFFFF);
    #2 reset_ni = 1'b0;
    #1;
    check("rst_done_out_valid", 32'(out_valid), 32'd0);
    check("rst_done_result", result, 32'd0);
    check("rst_done_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 reset_ni = 1'b1;
    out_ready = 1'b1;
    op = 3'd4; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset_ni = 1'b0;
    #1;
    check("rst_calc_out_valid", 32'(out_valid), 32'd0);
    check("rst_calc_result", result, 32'd0);
    check("rst_calc_in_ready", 32'(in_ready), 32'd1);
    check("rst_calc_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 reset_ni = 1'b1;
    @(posedge clk); #1;

    // unit still works after reset
    do_op(3'd6, -32'sd7, 32'd2, res, lat);
    check("post_rst_result", res, 32'hFFFFFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
